dev_int_ctrl: RTL

- Priority interrupt controller between the memory-mapped device CSRs (timer, keyboard, screen, traffic lights, pedestrian button) and the control unit.
- Latches device "data buffer available" events, arbitrates pending devices by programmable priority against the CPU's current priority, and presents one vector number to the control unit with a req/ack handshake.
- Replaces the tied-off pic_in path.

---
 rtl/dev_int_pkg.sv | 27 ++
 rtl/dev_int_ctrl_prio_arbiter.sv | 40 ++++
 rtl/dev_int_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dev_int_pkg.sv
// Shared constants for the device interrupt controller.
// Holds the device index map (matches the dev_mem CSR layout), the CSR bit
// positions used by the controller, the priority type and the FSM encoding.
package dev_int_pkg;

  // Device indices, as laid out in the dev_mem CSR map.
  localparam int unsigned DEV_TMR = 0;
  localparam int unsigned DEV_KB  = 1;
  localparam int unsigned DEV_SCR = 2;
  localparam int unsigned DEV_TL  = 3;
  localparam int unsigned DEV_PB  = 4;
  localparam int unsigned NUM_CSR = 5;

  // CSR bit positions. OF is owned by the device side and only observed here.
  localparam int unsigned CSR_IE  = 0;
  localparam int unsigned CSR_DBA = 2;
  localparam int unsigned CSR_OF  = 3;

  typedef logic [2:0] pri_t;

  // Controller FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_REQ   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/dev_int_ctrl_prio_arbiter.sv
// prio_arbiter: purely combinational winner selection.
// Ports:
//   pending   in  NDEV       per-device pending latches
//   pri       in  NDEV x 3   per-device programmed priority
//   cpu_pri   in  3          current CPU priority
//   win_valid out 1          at least one device is eligible
//   win_idx   out IW         index of the winning device
// A device is eligible when pending and its priority is strictly above
// cpu_pri. Highest priority wins; ties resolve to the lowest index.
module prio_arbiter
  import dev_int_pkg::*;
#(
  parameter int unsigned NDEV = 5,
  parameter int unsigned IW   = 3
) (
  input  logic [NDEV-1:0]       pending,
  input  pri_t [NDEV-1:0]       pri,
  input  pri_t                  cpu_pri,
  output logic                  win_valid,
  output logic [IW-1:0]         win_idx
);

  pri_t best;

  // Scanning upward and replacing only on a strictly greater priority
  // keeps the lowest index on ties.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    best      = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (pending[i] && (pri[i] > cpu_pri) && (!win_valid || (pri[i] > best))) begin
        win_valid = 1'b1;
        win_idx   = IW'(i);
        best      = pri[i];
      end
    end
  end

endmodule

// File: rtl/dev_int_ctrl.sv
// dev_int_ctrl: priority interrupt controller between device CSRs and the
// control unit. Latches rising "data buffer available" events per device,
// arbitrates against the CPU priority and presents one vector with a
// req/ack handshake.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   csr_tmr..csr_pb   device CSR bytes (bit0 IE, bit2 DBA, bit3 OF)
//   cpu_pri           current CPU priority (PSW[7:5])
//   cfg_we/dev/pri    priority register write port
//   int_ack           control unit accepted the presented vector
//   int_req           interrupt request
//   vect_num, int_pri vector and priority of the granted device
//   pending, ovr      per-device pending latches and sticky overrun flags
module dev_int_ctrl
  import dev_int_pkg::*;
#(
  parameter int unsigned NDEV      = 5,
  parameter logic [3:0]  VECT_BASE = 4'd8,
  parameter logic [2:0]  DEF_PRI   = 3'd1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      csr_tmr,
  input  logic [7:0]      csr_kb,
  input  logic [7:0]      csr_scr,
  input  logic [7:0]      csr_tl,
  input  logic [7:0]      csr_pb,
  input  logic [2:0]      cpu_pri,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_dev,
  input  logic [2:0]      cfg_pri,
  input  logic            int_ack,
  output logic            int_req,
  output logic [3:0]      vect_num,
  output logic [2:0]      int_pri,
  output logic [NDEV-1:0] pending,
  output logic [NDEV-1:0] ovr
);

  localparam int unsigned IW = (NDEV > 1) ? $clog2(NDEV) : 1;

  logic [NUM_CSR-1:0] ie_all;
  logic [NUM_CSR-1:0] dba_all;
  logic [NDEV-1:0]    ie;
  logic [NDEV-1:0]    dba;
  logic [NDEV-1:0]    dba_q;
  logic [NDEV-1:0]    ev;
  pri_t [NDEV-1:0]    pri_q;

  logic [1:0]         state;
  logic [IW-1:0]      g_q;
  logic               win_valid;
  logic [IW-1:0]      win_idx;
  pri_t               win_pri;
  logic               g_pend;
  pri_t               g_pri;
  logic               ack_fire;
  logic               withdraw;

  // OF and the remaining CSR bits belong to the device side.
  logic unused_csr;
  assign unused_csr = ^{csr_tmr, csr_kb, csr_scr, csr_tl, csr_pb};

  assign ie_all  = {csr_pb[CSR_IE],  csr_tl[CSR_IE],  csr_scr[CSR_IE],
                    csr_kb[CSR_IE],  csr_tmr[CSR_IE]};
  assign dba_all = {csr_pb[CSR_DBA], csr_tl[CSR_DBA], csr_scr[CSR_DBA],
                    csr_kb[CSR_DBA], csr_tmr[CSR_DBA]};
  assign ie  = NDEV'(ie_all);
  assign dba = NDEV'(dba_all);

  // An event is a DBA rising edge on an enabled device.
  assign ev = dba & ~dba_q & ie;

  prio_arbiter #(
    .NDEV (NDEV),
    .IW   (IW)
  ) u_arb (
    .pending   (pending),
    .pri       (pri_q),
    .cpu_pri   (cpu_pri),
    .win_valid (win_valid),
    .win_idx   (win_idx)
  );

  // Per-device lookups by the arbiter winner and the registered grant.
  always_comb begin
    win_pri = '0;
    g_pend  = 1'b0;
    g_pri   = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (win_idx == IW'(i)) win_pri = pri_q[i];
      if (g_q == IW'(i)) begin
        g_pend = pending[i];
        g_pri  = pri_q[i];
      end
    end
  end

  assign ack_fire = (state == ST_REQ) && int_ack;
  assign withdraw = (state == ST_REQ) && !int_ack && (!g_pend || (g_pri <= cpu_pri));

  always_ff @(posedge clk) begin
    if (rst) begin
      dba_q    <= '0;
      pri_q    <= {NDEV{DEF_PRI}};
      pending  <= '0;
      ovr      <= '0;
      state    <= ST_IDLE;
      g_q      <= '0;
      int_req  <= 1'b0;
      vect_num <= '0;
      int_pri  <= '0;
    end else begin
      dba_q <= dba;

      for (int unsigned i = 0; i < NDEV; i++) begin
        if (cfg_we && (cfg_dev == 3'(i))) pri_q[i] <= cfg_pri;

        // Disable dominates; an ack on the granted device clears it unless a
        // fresh event lands on the same edge, which keeps it pending.
        if (!ie[i]) begin
          pending[i] <= 1'b0;
          ovr[i]     <= 1'b0;
        end else if (ack_fire && (g_q == IW'(i))) begin
          pending[i] <= ev[i];
          ovr[i]     <= 1'b0;
        end else if (ev[i]) begin
          pending[i] <= 1'b1;
          if (pending[i]) ovr[i] <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            g_q      <= win_idx;
            vect_num <= VECT_BASE + 4'(win_idx);
            int_pri  <= win_pri;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          int_req <= 1'b1;
          state   <= ST_REQ;
        end
        ST_REQ: begin
          if (int_ack) begin
            int_req <= 1'b0;
            state   <= ST_DONE;
          end else if (withdraw) begin
            int_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
